// File: rtl/nvram_upload.sv
// nvram_upload: serves hps_io upload byte reads out of SDRAM through a
// one-word read cache. Misses stall hps_io with ioctl_wait while a single
// 32-bit word is fetched; hits and out-of-range reads answer next cycle.
module nvram_upload #(
  parameter logic [22:0] BASE_ADDR = 23'h0,
  parameter int unsigned SIZE      = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_valid,
  input  logic [31:0] sdram_q,
  output logic        sdram_we
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [24:0] addr_q;       // byte address of the outstanding miss
  logic [31:0] c_data;
  logic [22:0] c_tag;
  logic        c_valid;
  logic        upload_q;
  logic        abort;        // upload ended mid-transaction: drop the fill
  logic        upload_rise, upload_fall;
  logic        oor, hit, fill;
  logic [31:0] addr_ext;

  assign upload_rise = ioctl_upload & ~upload_q;
  assign upload_fall = ~ioctl_upload & upload_q;
  assign addr_ext    = {7'd0, ioctl_addr};
  assign oor         = (addr_ext >= SIZE);
  // A read on the same edge as a new upload must not hit the stale word.
  assign hit         = c_valid && !upload_rise && (c_tag == ioctl_addr[24:2]);
  // Data can arrive with the ack itself, or later while waiting.
  assign fill        = (state == REQ && sdram_ack && sdram_valid) ||
                       (state == WAIT && sdram_valid);

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] s);
    return w[{s, 3'b000} +: 8];
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ioctl_rd && !oor && !hit) state_nxt = REQ;
      REQ:  if (sdram_ack) state_nxt = sdram_valid ? DONE : WAIT;
      WAIT: if (sdram_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    sdram_req = (state == REQ);
    sdram_we  = 1'b0;
  end

  // Datapath: read response, miss address capture, cache and upload tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      sdram_addr <= 23'h0;
      addr_q     <= 25'h0;
      c_data     <= 32'h0;
      c_tag      <= 23'h0;
      c_valid    <= 1'b0;
      upload_q   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      case (state)
        IDLE: if (ioctl_rd) begin
          if (oor)      ioctl_din <= 8'hFF;
          else if (hit) ioctl_din <= sel_byte(c_data, ioctl_addr[1:0]);
          else begin
            addr_q     <= ioctl_addr;
            sdram_addr <= BASE_ADDR + ioctl_addr[24:2];
            ioctl_wait <= 1'b1;
          end
        end
        DONE: begin
          ioctl_din  <= sel_byte(c_data, addr_q[1:0]);
          ioctl_wait <= 1'b0;
        end
        default: ;
      endcase

      if (fill) begin
        c_data <= sdram_q;
        c_tag  <= addr_q[24:2];
      end

      if (upload_rise || (state == DONE && (abort || upload_fall))) c_valid <= 1'b0;
      else if (fill)                                                c_valid <= 1'b1;

      if (state == IDLE)    abort <= 1'b0;
      else if (upload_fall) abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: directed scenarios plus randomized reads against a
// cache/SDRAM reference model; a monitor pops expected responses.
module tb_nvram_upload;

  localparam logic [22:0] BASE = 23'h100;
  localparam int          SIZE = 1024;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        ioctl_upload = 0;
  logic        ioctl_rd = 0;
  logic [24:0] ioctl_addr = 0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 0;
  logic        sdram_valid = 0;
  logic [31:0] sdram_q = 0;
  logic        sdram_we;

  nvram_upload #(.BASE_ADDR(BASE), .SIZE(SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .sdram_q(sdram_q),
    .sdram_we(sdram_we)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; bit miss; bit chk; } exp_t;
  exp_t        dq[$];          // expected read responses
  logic [22:0] aq[$];          // expected SDRAM word addresses
  int          checks = 0;
  int          errors = 0;

  // SDRAM contents: explicit overrides, otherwise a hash of the address
  logic [31:0] mem [logic [22:0]];
  function automatic logic [31:0] wordval(input logic [22:0] a);
    logic [31:0] x;
    if (mem.exists(a)) return mem[a];
    x = {9'd0, a};
    return (x * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Reference cache model
  bit c_valid = 0;
  int c_tag = 0;

  // Responder configuration
  bit resp_en = 1, rnd = 0, fsame = 0;
  int fa = 0, fv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Model a read and queue what the DUT must answer
  task automatic expect_rd(input logic [24:0] a, input bit chk_data);
    exp_t        e;
    logic [22:0] w, wa;
    logic [31:0] v;
    e.chk = chk_data;
    if ({7'd0, a} >= SIZE) begin
      e.b = 8'hFF; e.miss = 0;
    end else begin
      w  = a[24:2];
      wa = BASE + w;
      if (c_valid && c_tag == int'(w)) e.miss = 0;
      else begin
        e.miss = 1; aq.push_back(wa); c_valid = 1; c_tag = int'(w);
      end
      v   = wordval(wa);
      e.b = v[8*a[1:0] +: 8];
    end
    dq.push_back(e);
  endtask

  task automatic strobe(input logic [24:0] a);
    ioctl_rd = 1; ioctl_addr = a;
    tick();
    ioctl_rd = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (dq.size() != 0 && n < 80) begin tick(); n++; end
    if (dq.size() != 0) begin fail("read_timeout"); dq.delete(); end
  endtask

  task automatic do_rd(input logic [24:0] a, input bit chk_data);
    expect_rd(a, chk_data);
    strobe(a);
    wait_done();
  endtask

  task automatic upload_pulse();
    ioctl_upload = 0; tick();
    ioctl_upload = 1; tick();
    c_valid = 0;
  endtask

  // SDRAM responder: ack after a delay, data with the ack or later
  initial begin
    int da, dv; bit same; logic [22:0] a;
    forever begin
      tick();
      if (resp_en && reset_n && sdram_req) begin
        da   = rnd ? $urandom_range(0, 3) : fa;
        dv   = rnd ? $urandom_range(0, 4) : fv;
        same = rnd ? ($urandom_range(0, 3) == 0) : fsame;
        repeat (da) tick();
        a = sdram_addr;
        sdram_ack = 1;
        if (same) begin sdram_valid = 1; sdram_q = wordval(a); end
        tick();
        sdram_ack = 0; sdram_valid = 0;
        if (!same) begin
          repeat (dv) tick();
          sdram_valid = 1; sdram_q = wordval(a);
          tick();
          sdram_valid = 0;
        end
      end
    end
  end

  // Monitor: response completion, request legality, output stability
  bit          rd_seen = 0, in_miss = 0, req_prev = 0, ack_prev = 0;
  logic [22:0] cur_addr = 0;
  logic [7:0]  last_din = 0;
  initial begin
    bit done_evt, miss_evt; exp_t e; logic [22:0] ea;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_seen = 0; in_miss = 0; req_prev = 0; ack_prev = 0; last_din = 0;
      end else begin
        if (sdram_req && !req_prev) begin
          if (aq.size() == 0) fail("unexpected_sdram_req");
          else begin ea = aq.pop_front(); chk("sdram_addr", {9'd0, sdram_addr}, {9'd0, ea}); end
          cur_addr = sdram_addr;
        end else if (sdram_req && sdram_addr !== cur_addr) fail("sdram_addr_unstable");
        if (sdram_req && ack_prev) fail("req_after_ack");
        req_prev = sdram_req; ack_prev = sdram_ack;

        done_evt = 0; miss_evt = 0;
        if (rd_seen) begin
          rd_seen = 0;
          if (ioctl_wait) in_miss = 1; else done_evt = 1;
        end else if (in_miss) begin
          if (!ioctl_wait) begin in_miss = 0; done_evt = 1; miss_evt = 1; end
        end else if (ioctl_wait) fail("spurious_wait");

        if (done_evt) begin
          if (dq.size() == 0) fail("unexpected_response");
          else begin
            e = dq.pop_front();
            chk("miss_flag", {31'd0, miss_evt}, {31'd0, e.miss});
            if (e.chk) chk("ioctl_din", {24'd0, ioctl_din}, {24'd0, e.b});
          end
        end else if (ioctl_din !== last_din) fail("ioctl_din_changed");
        last_din = ioctl_din;
        if (ioctl_rd) rd_seen = 1;
      end
    end
  end

  initial begin
    int k; int r; logic [31:0] a;
    // Reset values while reset is held
    repeat (3) tick();
    chk("rst_din", {24'd0, ioctl_din}, 32'h0);
    chk("rst_wait", {31'd0, ioctl_wait}, 32'h0);
    chk("rst_req", {31'd0, sdram_req}, 32'h0);
    chk("rst_addr", {9'd0, sdram_addr}, 32'h0);
    chk("sdram_we", {31'd0, sdram_we}, 32'h0);
    reset_n = 1; ioctl_upload = 1;
    tick(); tick();

    // Miss, then hits in the same word
    mem[BASE + 23'd1] = 32'hDDCCBBAA;
    fa = 1; fv = 2; fsame = 0;
    do_rd(25'd5, 1);
    do_rd(25'd6, 1);
    do_rd(25'd7, 1);

    // Out of range
    do_rd(25'd1024, 1);
    do_rd(25'h1FFFFFF, 1);

    // Ack and data in the same cycle
    mem[BASE] = 32'h00000042;
    fa = 0; fsame = 1;
    expect_rd(25'd0, 1);
    strobe(25'd0);
    k = 1;
    while (!(ioctl_wait == 0 && ioctl_din == 8'h42) && k < 10) begin tick(); k++; end
    chk("same_cycle_latency_le3", {31'd0, k <= 3}, 32'd1);
    wait_done();

    // New upload session invalidates the cache
    do_rd(25'd1, 1);
    upload_pulse();
    do_rd(25'd4, 1);
    do_rd(25'd4, 1);

    // Upload ends mid-transaction: fill completes but is not kept
    fa = 3; fv = 4; fsame = 0;
    fork
      do_rd(25'd100, 0);
      begin repeat (3) tick(); ioctl_upload = 0; end
    join
    c_valid = 0;
    chk("abort_wait", {31'd0, ioctl_wait}, 32'h0);
    do_rd(25'd101, 1);
    ioctl_upload = 1; tick(); tick();
    c_valid = 0;

    // Reset in WAIT, late data afterwards
    resp_en = 0;
    aq.push_back(BASE + 23'd10);
    strobe(25'd40);
    k = 0;
    while (!sdram_req && k < 20) begin tick(); k++; end
    if (!sdram_req) fail("reset_test_no_req");
    sdram_ack = 1; tick(); sdram_ack = 0; tick();
    reset_n = 0; tick();
    reset_n = 1; sdram_valid = 1; sdram_q = wordval(BASE + 23'd10);
    tick();
    sdram_valid = 0;
    c_valid = 0;
    chk("post_rst_din", {24'd0, ioctl_din}, 32'h0);
    chk("post_rst_wait", {31'd0, ioctl_wait}, 32'h0);
    chk("post_rst_req", {31'd0, sdram_req}, 32'h0);
    chk("post_rst_addr", {9'd0, sdram_addr}, 32'h0);
    aq.delete();
    resp_en = 1; fa = 1; fv = 1;
    tick(); tick();
    do_rd(25'd40, 1);

    // Randomized reads
    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 5) upload_pulse();
      r = $urandom_range(0, 99);
      if (r < 70)      a = $urandom_range(0, 63);
      else if (r < 85) a = SIZE - 4 + $urandom_range(0, 8);
      else             a = $urandom() & 32'h01FFFFFF;
      do_rd(a[24:0], 1);
    end
    repeat (5) tick();
    if (aq.size() != 0) fail("missing_sdram_req");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
